// File: rtl/insn_id_allocator.sv
// Instruction ID allocator: binds a free pool ID to each accepted instruction in a
// one-entry registered output stage and reclaims IDs when the commit controller retires them.
module insn_id_allocator #(
  parameter int unsigned InsnIDNum = 8,
  parameter int unsigned InsnW     = 32,
  parameter bit          AssertEn  = 1'b1,
  localparam int unsigned InsnIDW  = $clog2(InsnIDNum)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 insn_valid_i,
  input  logic [InsnW-1:0]     insn_i,
  output logic                 insn_ready_o,
  output logic                 insn_valid_o,
  output logic [InsnW-1:0]     insn_o,
  output logic [InsnIDW-1:0]   insn_id_o,
  input  logic                 insn_ready_i,
  input  logic                 done_i,
  input  logic [InsnIDW-1:0]   done_insn_id_i,
  output logic [InsnIDNum-1:0] inflight_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [InsnIDNum-1:0] inflight_q, inflight_d;
  logic [InsnIDNum-1:0] free;
  logic [InsnIDNum-1:0] alloc_mask, retire_mask;
  logic [InsnIDW-1:0]   alloc_id;
  logic                 accept;

  // Free pool comes from the registered mask only, so an ID retired this cycle
  // cannot be handed out again until the next cycle.
  assign free = ~inflight_q;

  always_comb begin
    alloc_id = '0;
    for (int i = InsnIDNum - 1; i >= 0; i--) begin
      if (free[i]) alloc_id = InsnIDW'(i);
    end
  end

  assign insn_ready_o = (|free) & (~insn_valid_o | insn_ready_i);
  assign accept       = insn_valid_i & insn_ready_o;

  always_comb begin
    alloc_mask  = '0;
    retire_mask = '0;
    if (accept) alloc_mask[alloc_id] = 1'b1;
    if (done_i) retire_mask[done_insn_id_i] = 1'b1;
  end

  assign inflight_d = (inflight_q & ~retire_mask) | alloc_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q   <= '0;
      insn_valid_o <= 1'b0;
      insn_o       <= '0;
      insn_id_o    <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (accept) begin
        insn_valid_o <= 1'b1;
        insn_o       <= insn_i;
        insn_id_o    <= alloc_id;
      end else if (insn_ready_i) begin
        insn_valid_o <= 1'b0;
      end
    end
  end

  assign inflight_o = inflight_q;
  assign full_o     = &inflight_q;
  assign empty_o    = ~|inflight_q;

`ifndef SYNTHESIS
  // Retiring a free ID, or the ID still parked in the output stage, indicates a
  // commit-side bookkeeping error; the mask update itself stays well-defined.
  always_ff @(posedge clk_i) begin
    if (AssertEn && rst_ni && done_i) begin
      assert (inflight_q[done_insn_id_i]);
      assert (!(insn_valid_o && !insn_ready_i && (insn_id_o == done_insn_id_i)));
    end
  end
`endif

endmodule

// File: tb/tb_insn_id_allocator.sv
// Directed, table-driven bench for insn_id_allocator with hand-computed expectations
// plus hand-written reset sequences.
module tb_insn_id_allocator;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        insn_valid_i;
  logic [31:0] insn_i;
  logic        insn_ready_o;
  logic        insn_valid_o;
  logic [31:0] insn_o;
  logic [2:0]  insn_id_o;
  logic        insn_ready_i;
  logic        done_i;
  logic [2:0]  done_insn_id_i;
  logic [7:0]  inflight_o;
  logic        full_o;
  logic        empty_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Spurious retires are exercised deliberately, so the design's retire checks are off.
  insn_id_allocator #(.InsnIDNum(8), .InsnW(32), .AssertEn(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .insn_valid_i(insn_valid_i), .insn_i(insn_i), .insn_ready_o(insn_ready_o),
    .insn_valid_o(insn_valid_o), .insn_o(insn_o), .insn_id_o(insn_id_o),
    .insn_ready_i(insn_ready_i), .done_i(done_i), .done_insn_id_i(done_insn_id_i),
    .inflight_o(inflight_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        vi;
    logic [31:0] insn;
    logic        ri;
    logic        dn;
    logic [2:0]  did;
    logic        exp_rdy;
    logic        exp_vo;
    logic [31:0] exp_insn;
    logic [2:0]  exp_id;
    logic [7:0]  exp_infl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic vi, logic [31:0] insn, logic ri, logic dn, logic [2:0] did,
                              logic exp_rdy, logic exp_vo, logic [31:0] exp_insn,
                              logic [2:0] exp_id, logic [7:0] exp_infl);
    vec_t v;
    v.vi = vi; v.insn = insn; v.ri = ri; v.dn = dn; v.did = did;
    v.exp_rdy = exp_rdy; v.exp_vo = exp_vo; v.exp_insn = exp_insn;
    v.exp_id = exp_id; v.exp_infl = exp_infl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " valid_o"},  {31'd0, insn_valid_o}, 32'd0);
    check({tag, " insn_o"},   insn_o, 32'd0);
    check({tag, " id_o"},     {29'd0, insn_id_o}, 32'd0);
    check({tag, " inflight"}, {24'd0, inflight_o}, 32'd0);
    check({tag, " full"},     {31'd0, full_o}, 32'd0);
    check({tag, " empty"},    {31'd0, empty_o}, 32'd1);
    check({tag, " ready_o"},  {31'd0, insn_ready_o}, 32'd1);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_i);
      insn_valid_i   = vq[i].vi;
      insn_i         = vq[i].insn;
      insn_ready_i   = vq[i].ri;
      done_i         = vq[i].dn;
      done_insn_id_i = vq[i].did;
      #1;
      check($sformatf("%s[%0d] ready_o", tag, i), {31'd0, insn_ready_o}, {31'd0, vq[i].exp_rdy});
      @(posedge clk_i);
      #1;
      check($sformatf("%s[%0d] valid_o", tag, i), {31'd0, insn_valid_o}, {31'd0, vq[i].exp_vo});
      check($sformatf("%s[%0d] insn_o", tag, i), insn_o, vq[i].exp_insn);
      check($sformatf("%s[%0d] id_o", tag, i), {29'd0, insn_id_o}, {29'd0, vq[i].exp_id});
      check($sformatf("%s[%0d] inflight", tag, i), {24'd0, inflight_o}, {24'd0, vq[i].exp_infl});
      check($sformatf("%s[%0d] full", tag, i), {31'd0, full_o}, {31'd0, &vq[i].exp_infl});
      check($sformatf("%s[%0d] empty", tag, i), {31'd0, empty_o}, {31'd0, ~|vq[i].exp_infl});
    end
    vq.delete();
  endtask

  initial begin
    rst_ni         = 1'b0;
    insn_valid_i   = 1'b0;
    insn_i         = '0;
    insn_ready_i   = 1'b1;
    done_i         = 1'b0;
    done_insn_id_i = '0;

    repeat (2) @(negedge clk_i);
    check_reset_state("por");
    rst_ni = 1'b1;

    // Phase A: first accept, fill the pool in order, stall at full, retire id 3, refill.
    vq.push_back(mk(1, 32'hA, 1, 0, 0,  1, 1, 32'hA, 0, 8'h01));
    for (int k = 1; k < 8; k++)
      vq.push_back(mk(1, 32'h10 + k, 1, 0, 0,  1, 1, 32'h10 + k, 3'(k), 8'((1 << (k + 1)) - 1)));
    vq.push_back(mk(1, 32'h99, 1, 0, 0,  0, 0, 32'h17, 7, 8'hFF));
    vq.push_back(mk(1, 32'h99, 1, 1, 3,  0, 0, 32'h17, 7, 8'hF7));
    vq.push_back(mk(1, 32'h99, 1, 0, 0,  1, 1, 32'h99, 3, 8'hFF));
    run_vecs("fill");

    // Asynchronous reset mid-cycle with a full pool and an occupied output stage.
    #2;
    rst_ni = 1'b0;
    insn_valid_i = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Phase B: post-reset alloc, spurious retire, same-cycle retire+alloc, stall, drain.
    vq.push_back(mk(1, 32'h60, 1, 0, 0,  1, 1, 32'h60, 0, 8'h01));
    vq.push_back(mk(0, 32'h0,  1, 1, 5,  1, 0, 32'h60, 0, 8'h01));
    vq.push_back(mk(1, 32'h61, 1, 0, 0,  1, 1, 32'h61, 1, 8'h03));
    vq.push_back(mk(1, 32'h62, 1, 1, 0,  1, 1, 32'h62, 2, 8'h06));
    vq.push_back(mk(1, 32'h63, 1, 0, 0,  1, 1, 32'h63, 0, 8'h07));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(1, 32'h44 + k, 0, 0, 0,  0, 1, 32'h63, 0, 8'h07));
    vq.push_back(mk(0, 32'h0, 1, 0, 0,  1, 0, 32'h63, 0, 8'h07));
    vq.push_back(mk(0, 32'h0, 1, 1, 1,  1, 0, 32'h63, 0, 8'h05));
    vq.push_back(mk(0, 32'h0, 1, 1, 0,  1, 0, 32'h63, 0, 8'h04));
    vq.push_back(mk(0, 32'h0, 1, 1, 2,  1, 0, 32'h63, 0, 8'h00));
    run_vecs("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
